// File: rtl/jam_seq.sv
// Assignment-problem sequencer: loads an 8x8 cost table from ROM, walks every subset DP relaxation.
// Optional build macro JAM_SEQ_SKIP_SET_EN: skip jobs already in the source mask instead of issuing them.
module jam_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic       ld_we,
  output logic [5:0] ld_addr,
  output logic [6:0] ld_data,
  output logic       dp_clr,
  output logic       relax_req,
  output logic [7:0] relax_mask,
  output logic [2:0] relax_job,
  input  logic       relax_ack,
  input  logic [9:0] min_cost,
  input  logic [3:0] match_in,
  output logic [9:0] MinCost,
  output logic [3:0] MatchCount,
  output logic       Valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    CAL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_r;
  logic       retire_s;
  logic       last_s;
  logic [2:0] nxt_job_s;
  logic [7:0] nxt_mask_s;
  logic       nxt_req_s;

  // Cost arrives one cycle after its address, alongside the registered ld_addr, so it passes straight through.
  assign ld_data = ld_we ? Cost : 7'd0;

  // Next relax command and retirement of the current one; a skipped job retires without a handshake.
  always_comb begin
    retire_s   = relax_req ? relax_ack : 1'b1;
    last_s     = (relax_mask == 8'd254) && (relax_job == 3'd7);
    nxt_job_s  = relax_job + 3'd1;
    nxt_mask_s = (relax_job == 3'd7) ? (relax_mask + 8'd1) : relax_mask;
`ifdef JAM_SEQ_SKIP_SET_EN
    nxt_req_s  = ~nxt_mask_s[nxt_job_s];
`else
    nxt_req_s  = 1'b1;
`endif
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      W          <= 3'd0;
      J          <= 3'd0;
      ld_we      <= 1'b0;
      ld_addr    <= 6'd0;
      dp_clr     <= 1'b0;
      relax_req  <= 1'b0;
      relax_mask <= 8'd0;
      relax_job  <= 3'd0;
      MinCost    <= 10'd0;
      MatchCount <= 4'd0;
      Valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dp_clr <= 1'b0;
      case (state_r)
        IDLE: begin
          ld_we     <= 1'b0;
          relax_req <= 1'b0;
          if (start) begin
            state_r <= FETCH;
            dp_clr  <= 1'b1;
            Valid   <= 1'b0;
            W       <= 3'd0;
            J       <= 3'd0;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          ld_we   <= 1'b1;
          ld_addr <= {W, J};
          if ({W, J} == 6'd63) begin
            state_r <= DRAIN;
          end else begin
            {W, J} <= {W, J} + 6'd1;
          end
        end
        DRAIN: begin
          ld_we      <= 1'b0;
          state_r    <= CAL;
          relax_req  <= 1'b1;
          relax_mask <= 8'd0;
          relax_job  <= 3'd0;
        end
        CAL: begin
          if (retire_s) begin
            if (last_s) begin
              relax_req <= 1'b0;
              state_r   <= DONE;
            end else begin
              relax_mask <= nxt_mask_s;
              relax_job  <= nxt_job_s;
              relax_req  <= nxt_req_s;
            end
          end
        end
        DONE: begin
          MinCost    <= min_cost;
          MatchCount <= match_in;
          Valid      <= 1'b1;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          ld_we     <= 1'b0;
          relax_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_seq.sv
// Bench for jam_seq: ROM model (Cost=W+J), reference DP datapath, scoreboards for table writes and relax commands.
module tb_jam_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       ld_we;
  logic [5:0] ld_addr;
  logic [6:0] ld_data;
  logic       dp_clr;
  logic       relax_req;
  logic [7:0] relax_mask;
  logic [2:0] relax_job;
  logic       relax_ack;
  logic [9:0] min_cost;
  logic [3:0] match_in;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic       Valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef JAM_SEQ_SKIP_SET_EN
  localparam int EXP_HS = 1024;
`else
  localparam int EXP_HS = 2040;
`endif

  jam_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .W(W), .J(J), .Cost(Cost),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .dp_clr(dp_clr),
    .relax_req(relax_req), .relax_mask(relax_mask), .relax_job(relax_job),
    .relax_ack(relax_ack), .min_cost(min_cost), .match_in(match_in),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // ROM: registered read of W+J
  logic [6:0] cost_q;
  always @(posedge CLK) cost_q <= 7'(W) + 7'(J);
  assign Cost = cost_q;

  // Acknowledge responder: tied high, or ack in the 4th cycle of each pending command
  logic ack_mode;
  int   wait_cnt = 0;
  assign relax_ack = ack_mode ? (relax_req && wait_cnt == 3) : 1'b1;
  always @(posedge CLK) wait_cnt <= (relax_req && !relax_ack) ? wait_cnt + 1 : 0;

  // Reference datapath: cost table, dp[] minimum and count[] of optimal predecessors
  logic [6:0] cost_tab [64];
  logic [9:0] dp [256];
  logic [3:0] cnt [256];
  logic [7:0] tgt;
  logic [2:0] src_w;
  logic [9:0] nv;
  assign tgt   = relax_mask | (8'd1 << relax_job);
  assign src_w = 3'($countones(relax_mask));
  assign nv    = dp[relax_mask] + 10'(cost_tab[{src_w, relax_job}]);
  assign min_cost = dp[255];
  assign match_in = cnt[255];

  always @(posedge CLK) begin
    if (ld_we) cost_tab[ld_addr] <= ld_data;
    if (dp_clr) begin
      for (int i = 1; i < 256; i++) begin
        dp[i]  <= 10'd1023;
        cnt[i] <= 4'd0;
      end
      dp[0]  <= 10'd0;
      cnt[0] <= 4'd1;
    end else if (relax_req && relax_ack && !relax_mask[relax_job]) begin
      if (nv < dp[tgt]) begin
        dp[tgt]  <= nv;
        cnt[tgt] <= 4'd1;
      end else if (nv == dp[tgt]) begin
        cnt[tgt] <= cnt[tgt] + 4'd1;
      end
    end
  end

  logic [48:0] all_outs;
  assign all_outs = {W, J, ld_we, ld_addr, ld_data, dp_clr, relax_req, relax_mask,
                     relax_job, MinCost, MatchCount, Valid, busy};

  logic [12:0] exp_ld [$];
  logic [10:0] exp_cmd [$];
  int n_wr, n_hs, n_clr, hold_0f4;

  task automatic fill_expect();
    logic [5:0] a6;
    logic [7:0] m8;
    logic [2:0] j3;
    exp_ld.delete();
    exp_cmd.delete();
    for (int a = 0; a < 64; a++) begin
      a6 = 6'(a);
      exp_ld.push_back({a6, 7'(a6[5:3]) + 7'(a6[2:0])});
    end
    for (int m = 0; m < 255; m++) begin
      for (int j = 0; j < 8; j++) begin
        m8 = 8'(m);
        j3 = 3'(j);
`ifdef JAM_SEQ_SKIP_SET_EN
        if (!m8[j3]) exp_cmd.push_back({m8, j3});
`else
        exp_cmd.push_back({m8, j3});
`endif
      end
    end
  endtask

  task automatic start_run();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    total++;
    if ({busy, dp_clr, Valid, W, J} !== {1'b1, 1'b1, 1'b0, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL run_start: busy/dp_clr/Valid/W/J=%b %b %b %0d %0d required 1 1 0 0 0",
               busy, dp_clr, Valid, W, J);
    end
  endtask

  task automatic run_monitor(input int budget, input bit chk_stab);
    int cyc = 0;
    logic pend = 1'b0;
    logic [10:0] prev = 11'd0;
    logic [12:0] e13;
    logic [10:0] e11;
    n_wr = 0; n_hs = 0; n_clr = 0; hold_0f4 = 0;
    while (cyc < budget && !Valid) begin
      @(negedge CLK);
      cyc++;
      if (chk_stab && pend) begin
        total++;
        if (!relax_req || {relax_mask, relax_job} !== prev) begin
          bad++;
          $display("FAIL cmd_stable: req=%b mask=%h job=%0d required req=1 {mask,job}=%h",
                   relax_req, relax_mask, relax_job, prev);
        end
      end
      if (ld_we) begin
        n_wr++;
        total++;
        if (exp_ld.size() == 0) begin
          bad++;
          $display("FAIL ld_write: extra write addr=%0d data=%0d", ld_addr, ld_data);
        end else begin
          e13 = exp_ld.pop_front();
          if ({ld_addr, ld_data} !== e13) begin
            bad++;
            $display("FAIL ld_write: addr=%0d data=%0d required addr=%0d data=%0d",
                     ld_addr, ld_data, e13[12:7], e13[6:0]);
          end
        end
      end
      if (relax_req && relax_ack) begin
        n_hs++;
        total++;
        if (exp_cmd.size() == 0) begin
          bad++;
          $display("FAIL relax_cmd: extra command mask=%h job=%0d", relax_mask, relax_job);
        end else begin
          e11 = exp_cmd.pop_front();
          if ({relax_mask, relax_job} !== e11) begin
            bad++;
            $display("FAIL relax_cmd: mask=%h job=%0d required mask=%h job=%0d",
                     relax_mask, relax_job, e11[10:3], e11[2:0]);
          end
        end
      end
      if (dp_clr) n_clr++;
      if (relax_req && relax_mask == 8'h0F && relax_job == 3'd4) hold_0f4++;
      pend = relax_req && !relax_ack;
      prev = {relax_mask, relax_job};
    end
    total++;
    if (!Valid) begin
      bad++;
      $display("FAIL run_timeout: Valid=0 after %0d cycles required 1", cyc);
    end
  endtask

  task automatic check_result(input string tag);
    total++;
    if (n_wr !== 64 || n_hs !== EXP_HS || n_clr !== 0) begin
      bad++;
      $display("FAIL %s_counts: writes=%0d hs=%0d extra_clr=%0d required 64 %0d 0",
               tag, n_wr, n_hs, n_clr, EXP_HS);
    end
    total++;
    if ({MinCost, MatchCount, Valid, busy} !== {10'd56, 4'd8, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s_result: MinCost=%0d MatchCount=%0d Valid=%b busy=%b required 56 8 1 0",
               tag, MinCost, MatchCount, Valid, busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; ack_mode = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (all_outs !== 49'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", all_outs);
    end
    RST = 1'b0;
  endtask

  task automatic test_run_tied();
    ack_mode = 1'b0;
    fill_expect();
    start_run();
    run_monitor(6000, 1'b0);
    check_result("tied");
    repeat (5) @(negedge CLK);
    total++;
    if ({MatchCount, MinCost, Valid, W, J} !== {4'd8, 10'd56, 1'b1, 3'd7, 3'd7}) begin
      bad++;
      $display("FAIL result_hold: MatchCount=%0d MinCost=%0d Valid=%b W=%0d J=%0d required 8 56 1 7 7",
               MatchCount, MinCost, Valid, W, J);
    end
  endtask

  task automatic test_delayed_ack();
    ack_mode = 1'b1;
    fill_expect();
    start_run();
    run_monitor(20000, 1'b1);
    check_result("delayed");
    total++;
    if (hold_0f4 !== 4) begin
      bad++;
      $display("FAIL hold_0f_4: held %0d cycles required 4", hold_0f4);
    end
  endtask

  task automatic test_reset_mid_cal();
    bit found = 1'b0;
    ack_mode = 1'b0;
    fill_expect();
    start_run();
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge CLK);
      if (relax_req && relax_mask == 8'h37) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_mask37: command mask 37 not seen required seen");
    end
    RST = 1'b1;
    #1;
    total++;
    if (all_outs !== 49'd0) begin
      bad++;
      $display("FAIL reset_in_cal: got %h required 0", all_outs);
    end
    @(negedge CLK);
    RST = 1'b0;
    fill_expect();
    start_run();
    run_monitor(6000, 1'b0);
    check_result("rerun");
  endtask

  task automatic test_start_held();
    int clr_cnt = 0;
    ack_mode = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    if (dp_clr) clr_cnt++;
    for (int c = 0; c < 3000 && !Valid; c++) begin
      @(negedge CLK);
      if (dp_clr) clr_cnt++;
    end
    total++;
    if (clr_cnt !== 1 || busy !== 1'b0 || Valid !== 1'b1) begin
      bad++;
      $display("FAIL held_first_run: dp_clr pulses=%0d busy=%b Valid=%b required 1 0 1",
               clr_cnt, busy, Valid);
    end
    @(negedge CLK);
    total++;
    if ({busy, dp_clr, Valid, W, J} !== {1'b1, 1'b1, 1'b0, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL held_second_run: busy/dp_clr/Valid/W/J=%b %b %b %0d %0d required 1 1 0 0 0",
               busy, dp_clr, Valid, W, J);
    end
    start = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_tied();
    test_delayed_ack();
    test_reset_mid_cal();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
